// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 16-bit pipeline.
// Single-cycle ALU ops resolve combinationally; MUL/DIV/REM run on an
// iterative shift-add / restoring-divide engine while eeo_stall holds the
// upstream stages and bubbles EXE/MEM.
// Ports:
//   iei_clk, iei_rst (async, active-low), iei_en (0 = flush)
//   eei_alu_opcode, eei_op1, eei_op2     : instruction from ID/EXE
//   eei_wreg_addr, eei_rwe, eei_write_to_mem_data : forwarded fields
//   eeo_result, eeo_wreg_addr, eeo_rwe, eeo_write_to_mem_data : to EXE/MEM
//   eeo_stall : hold PC, IF/ID, ID/EXE and bubble EXE/MEM
//   eeo_busy  : iterative engine not idle
module exe_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic             iei_clk,
    input  logic             iei_rst,
    input  logic             iei_en,
    input  logic [7:0]       eei_alu_opcode,
    input  logic [WIDTH-1:0] eei_op1,
    input  logic [WIDTH-1:0] eei_op2,
    input  logic [3:0]       eei_wreg_addr,
    input  logic [1:0]       eei_rwe,
    input  logic [WIDTH-1:0] eei_write_to_mem_data,
    output logic [WIDTH-1:0] eeo_result,
    output logic [3:0]       eeo_wreg_addr,
    output logic [1:0]       eeo_rwe,
    output logic [WIDTH-1:0] eeo_write_to_mem_data,
    output logic             eeo_stall,
    output logic             eeo_busy
);

    localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [3:0] REG_INVALID = 4'hF;
    localparam logic [1:0] RWE_IDLE    = 2'b00;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_SLL  = 8'h06;
    localparam logic [7:0] OP_SRL  = 8'h07;
    localparam logic [7:0] OP_SRA  = 8'h08;
    localparam logic [7:0] OP_SLT  = 8'h09;
    localparam logic [7:0] OP_SLTU = 8'h0A;
    localparam logic [7:0] OP_MUL  = 8'h0B;
    localparam logic [7:0] OP_DIV  = 8'h0C;
    localparam logic [7:0] OP_REM  = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_op;
    logic [WIDTH-1:0] r_a;    // multiplicand (shifts left) / dividend->quotient
    logic [WIDTH-1:0] r_b;    // multiplier (shifts right) / divisor
    logic [WIDTH:0]   r_acc;  // product / partial remainder

    logic             w_is_iter;
    logic             w_div0;
    logic             w_start;
    logic [SW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;

    // Divide-by-zero is answered by the single-cycle path, never the engine.
    assign w_is_iter = (eei_alu_opcode == OP_MUL) || (eei_alu_opcode == OP_DIV) ||
                       (eei_alu_opcode == OP_REM);
    assign w_div0    = ((eei_alu_opcode == OP_DIV) || (eei_alu_opcode == OP_REM)) &&
                       (eei_op2 == '0);
    assign w_start   = (r_state == S_IDLE) && iei_en && w_is_iter && !w_div0;
    assign w_shamt   = eei_op2[SW-1:0];

    // One engine step: shift-add for MUL, shift-compare-subtract for DIV/REM.
    assign w_addend  = r_b[0] ? r_a : '0;
    assign w_mul_acc = r_acc + {1'b0, w_addend};
    assign w_rem_sh  = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};

    // Single-cycle ALU.
    always_comb begin
        w_alu = '0;
        case (eei_alu_opcode)
            OP_ADD:  w_alu = eei_op1 + eei_op2;
            OP_SUB:  w_alu = eei_op1 - eei_op2;
            OP_AND:  w_alu = eei_op1 & eei_op2;
            OP_OR:   w_alu = eei_op1 | eei_op2;
            OP_XOR:  w_alu = eei_op1 ^ eei_op2;
            OP_SLL:  w_alu = eei_op1 << w_shamt;
            OP_SRL:  w_alu = eei_op1 >> w_shamt;
            OP_SRA:  w_alu = WIDTH'($signed(eei_op1) >>> w_shamt);
            OP_SLT:  w_alu = WIDTH'($signed(eei_op1) < $signed(eei_op2));
            OP_SLTU: w_alu = WIDTH'(eei_op1 < eei_op2);
            OP_DIV:  w_alu = w_div0 ? '1 : '0;
            OP_REM:  w_alu = w_div0 ? eei_op1 : '0;
            default: w_alu = '0;
        endcase
    end

    // Final engine result, selected by the latched opcode.
    always_comb begin
        w_iter_res = r_acc[WIDTH-1:0];
        case (r_op)
            OP_DIV:  w_iter_res = r_a;
            default: w_iter_res = r_acc[WIDTH-1:0];
        endcase
    end

    // Engine FSM and datapath.
    always_ff @(posedge iei_clk or negedge iei_rst) begin
        if (!iei_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (!iei_en) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a     <= eei_op1;
                        r_b     <= eei_op2;
                        r_op    <= eei_alu_opcode;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else if (!w_diff[WIDTH]) begin
                        r_acc <= w_diff;
                        r_a   <= {r_a[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_rem_sh;
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(STEPS - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output steering: reset, then flush, then stall bubble, then normal.
    always_comb begin
        eeo_result            = w_alu;
        eeo_wreg_addr         = eei_wreg_addr;
        eeo_rwe               = eei_rwe;
        eeo_write_to_mem_data = eei_write_to_mem_data;
        eeo_stall             = 1'b0;
        if (!iei_rst) begin
            eeo_result            = '0;
            eeo_wreg_addr         = REG_INVALID;
            eeo_rwe               = RWE_IDLE;
            eeo_write_to_mem_data = '0;
        end else if (!iei_en) begin
            eeo_result    = '0;
            eeo_wreg_addr = REG_INVALID;
            eeo_rwe       = RWE_IDLE;
        end else if (w_start || (r_state == S_RUN)) begin
            eeo_stall     = 1'b1;
            eeo_result    = '0;
            eeo_wreg_addr = REG_INVALID;
            eeo_rwe       = RWE_IDLE;
        end else if (r_state == S_DONE) begin
            eeo_result = w_iter_res;
        end
    end

    assign eeo_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: self-checking bench for exe_stage (vector table + scoreboard).
module tb_exe_stage;

    logic        iei_clk = 1'b0;
    logic        iei_rst;
    logic        iei_en;
    logic [7:0]  eei_alu_opcode;
    logic [15:0] eei_op1;
    logic [15:0] eei_op2;
    logic [3:0]  eei_wreg_addr;
    logic [1:0]  eei_rwe;
    logic [15:0] eei_write_to_mem_data;
    logic [15:0] eeo_result;
    logic [3:0]  eeo_wreg_addr;
    logic [1:0]  eeo_rwe;
    logic [15:0] eeo_write_to_mem_data;
    logic        eeo_stall;
    logic        eeo_busy;

    exe_stage dut (
        .iei_clk               (iei_clk),
        .iei_rst               (iei_rst),
        .iei_en                (iei_en),
        .eei_alu_opcode        (eei_alu_opcode),
        .eei_op1               (eei_op1),
        .eei_op2               (eei_op2),
        .eei_wreg_addr         (eei_wreg_addr),
        .eei_rwe               (eei_rwe),
        .eei_write_to_mem_data (eei_write_to_mem_data),
        .eeo_result            (eeo_result),
        .eeo_wreg_addr         (eeo_wreg_addr),
        .eeo_rwe               (eeo_rwe),
        .eeo_write_to_mem_data (eeo_write_to_mem_data),
        .eeo_stall             (eeo_stall),
        .eeo_busy              (eeo_busy)
    );

    always #5 iei_clk = ~iei_clk;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] result;
        logic [3:0]  wreg;
        logic [1:0]  rwe;
        logic [15:0] wdata;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference behaviour written directly from the opcode definitions.
    function automatic logic [15:0] model(input logic [7:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic signed [15:0] sa;
        logic [31:0]        prod;
        sa   = a;
        prod = 32'(a) * 32'(b);
        case (op)
            8'h01:   return a + b;
            8'h02:   return a - b;
            8'h03:   return a & b;
            8'h04:   return a | b;
            8'h05:   return a ^ b;
            8'h06:   return a << b[3:0];
            8'h07:   return a >> b[3:0];
            8'h08:   return 16'(sa >>> b[3:0]);
            8'h09:   return ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
            8'h0A:   return (a < b) ? 16'h0001 : 16'h0000;
            8'h0B:   return prod[15:0];
            8'h0C:   return (b == 16'h0) ? 16'hFFFF : a / b;
            8'h0D:   return (b == 16'h0) ? a : a % b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit is_iter(input logic [7:0] op, input logic [15:0] b);
        if (op == 8'h0B) return 1'b1;
        if ((op == 8'h0C || op == 8'h0D) && b != 16'h0) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one instruction at posedge+1, track its stall window, compare on output.
    task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input logic [3:0] wr, input logic [1:0] rwe,
                         input logic [15:0] wd, input bit scramble);
        exp_t e;
        int   stalls;
        bit   done;
        e.result = exp;
        e.wreg   = wr;
        e.rwe    = rwe;
        e.wdata  = wd;
        e.stalls = is_iter(op, b) ? 17 : 0;
        sb.push_back(e);
        iei_en                = 1'b1;
        eei_alu_opcode        = op;
        eei_op1               = a;
        eei_op2               = b;
        eei_wreg_addr         = wr;
        eei_rwe               = rwe;
        eei_write_to_mem_data = wd;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge iei_clk);
            if (!eeo_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                check("bubble", {10'h0, eeo_result, eeo_wreg_addr, eeo_rwe},
                      {10'h0, 16'h0000, 4'hF, 2'b00});
                @(posedge iei_clk);
                #1;
                if (scramble) begin
                    eei_op1 = 16'($urandom);
                    eei_op2 = 16'($urandom);
                end
            end
        end
        if (!done) check("stall_timeout", 32'(stalls), 32'(e.stalls));
        e = sb.pop_front();
        check("result", {16'h0, eeo_result}, {16'h0, e.result});
        check("wreg", {28'h0, eeo_wreg_addr}, {28'h0, e.wreg});
        check("rwe", {30'h0, eeo_rwe}, {30'h0, e.rwe});
        check("wdata", {16'h0, eeo_write_to_mem_data}, {16'h0, e.wdata});
        check("stall_cycles", 32'(stalls), 32'(e.stalls));
        check("busy_at_output", {31'h0, eeo_busy}, {31'h0, (e.stalls != 0)});
        @(posedge iei_clk);
        #1;
    endtask

    vec_t vt[19];

    initial begin
        vt[0]  = '{8'h01, 16'h7FFF, 16'h0001, 16'h8000};
        vt[1]  = '{8'h02, 16'h0000, 16'h0001, 16'hFFFF};
        vt[2]  = '{8'h09, 16'hFFFF, 16'h0001, 16'h0001};
        vt[3]  = '{8'h0A, 16'hFFFF, 16'h0001, 16'h0000};
        vt[4]  = '{8'h08, 16'h8000, 16'h0004, 16'hF800};
        vt[5]  = '{8'h0B, 16'h0123, 16'h0010, 16'h1230};
        vt[6]  = '{8'h0C, 16'd100,  16'd7,    16'd14};
        vt[7]  = '{8'h0D, 16'd100,  16'd7,    16'd2};
        vt[8]  = '{8'h0C, 16'd5,    16'd0,    16'hFFFF};
        vt[9]  = '{8'h0D, 16'd9,    16'd0,    16'd9};
        vt[10] = '{8'h03, 16'hF0F0, 16'hFF00, 16'hF000};
        vt[11] = '{8'h04, 16'hF0F0, 16'h0F0F, 16'hFFFF};
        vt[12] = '{8'h05, 16'hAAAA, 16'hFFFF, 16'h5555};
        vt[13] = '{8'h06, 16'h0001, 16'h0013, 16'h0008};
        vt[14] = '{8'h07, 16'h8000, 16'h000F, 16'h0001};
        vt[15] = '{8'h00, 16'h1234, 16'h5678, 16'h0000};
        vt[16] = '{8'hFF, 16'h1234, 16'h5678, 16'h0000};
        vt[17] = '{8'h0B, 16'hFFFF, 16'hFFFF, 16'h0001};
        vt[18] = '{8'h0C, 16'hFFFF, 16'h0001, 16'hFFFF};

        // Reset values with non-idle inputs present.
        iei_rst               = 1'b0;
        iei_en                = 1'b1;
        eei_alu_opcode        = 8'h01;
        eei_op1               = 16'h0001;
        eei_op2               = 16'h0001;
        eei_wreg_addr         = 4'h3;
        eei_rwe               = 2'b10;
        eei_write_to_mem_data = 16'hAAAA;
        #2;
        check("rst_result", {16'h0, eeo_result}, 32'h0);
        check("rst_wreg", {28'h0, eeo_wreg_addr}, 32'hF);
        check("rst_rwe", {30'h0, eeo_rwe}, 32'h0);
        check("rst_wdata", {16'h0, eeo_write_to_mem_data}, 32'h0);
        check("rst_stall", {31'h0, eeo_stall}, 32'h0);
        check("rst_busy", {31'h0, eeo_busy}, 32'h0);
        @(negedge iei_clk);
        iei_rst = 1'b1;
        @(posedge iei_clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 4'(i % 15), 2'(i % 4),
                  16'($urandom), (i % 2) == 1);
        end

        for (int i = 0; i < 8; i++) begin
            logic [7:0]  op;
            logic [15:0] a, b;
            op = 8'($urandom_range(1, 13));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            issue(op, a, b, model(op, a, b), 4'(i), 2'(i % 4), 16'($urandom), 1'b1);
        end

        // Flush in the middle of a MUL.
        eei_alu_opcode = 8'h0B;
        eei_op1        = 16'h0123;
        eei_op2        = 16'h0010;
        eei_wreg_addr  = 4'h5;
        eei_rwe        = 2'b01;
        repeat (6) @(posedge iei_clk);
        #1;
        check("run_busy", {31'h0, eeo_busy}, 32'h1);
        iei_en = 1'b0;
        @(negedge iei_clk);
        check("flush_stall", {31'h0, eeo_stall}, 32'h0);
        check("flush_bubble", {10'h0, eeo_result, eeo_wreg_addr, eeo_rwe},
              {10'h0, 16'h0000, 4'hF, 2'b00});
        @(posedge iei_clk);
        #1;
        check("flush_idle", {31'h0, eeo_busy}, 32'h0);
        issue(8'h01, 16'h0002, 16'h0003, 16'h0005, 4'h6, 2'b00, 16'h1111, 1'b0);

        // Reset in the middle of a DIV.
        eei_alu_opcode        = 8'h0C;
        eei_op1               = 16'd100;
        eei_op2               = 16'd7;
        eei_write_to_mem_data = 16'h5A5A;
        repeat (9) @(posedge iei_clk);
        #1;
        iei_rst = 1'b0;
        #1;
        check("mid_rst_stall", {31'h0, eeo_stall}, 32'h0);
        check("mid_rst_busy", {31'h0, eeo_busy}, 32'h0);
        check("mid_rst_outs", {6'h0, eeo_result, eeo_wreg_addr, eeo_rwe, 4'h0},
              {6'h0, 16'h0000, 4'hF, 2'b00, 4'h0});
        check("mid_rst_wdata", {16'h0, eeo_write_to_mem_data}, 32'h0);
        eei_alu_opcode = 8'h00;
        @(negedge iei_clk);
        iei_rst = 1'b1;
        @(posedge iei_clk);
        #1;
        check("post_rst_idle", {31'h0, eeo_busy}, 32'h0);
        issue(8'h0C, 16'd100, 16'd7, 16'd14, 4'h2, 2'b01, 16'h2222, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 16-bit pipeline. Sits directly downstream of the ID/EXE pipeline register and upstream of the EXE/MEM register.
- Single-cycle ALU ops complete combinationally.
- MUL/DIV/REM run on an iterative 16-step engine. While it runs, the block drives eeo_stall, which the hazard logic feeds to the keep inputs of PC, IF/ID and ID/EXE, and which forces a bubble into EXE/MEM.

Parameters:
- WIDTH, 16, datapath width
- STEPS, 16, iterations per multiply/divide (= WIDTH)

Ports:
- iei_clk  in  1  clock, rising edge
- iei_rst  in  1  reset, asynchronous, active-low
- iei_en  in  1  0 = flush: abort any operation, emit a bubble
- eei_alu_opcode  in  8  opcode from ID/EXE
- eei_op1  in  16  operand 1
- eei_op2  in  16  operand 2
- eei_wreg_addr  in  4  destination register, `REG_INVALID = none
- eei_rwe  in  2  memory read/write enable (`RWE_IDLE / read / write)
- eei_write_to_mem_data  in  16  store data
- eeo_result  out  16  ALU result / memory address
- eeo_wreg_addr  out  4  forwarded destination
- eeo_rwe  out  2  forwarded memory control
- eeo_write_to_mem_data  out  16  forwarded store data
- eeo_stall  out  1  1 = hold upstream stages, bubble downstream
- eeo_busy  out  1  1 while the FSM is not IDLE

Behaviour:
- Opcodes: NOP 00, ADD 01, SUB 02, AND 03, OR 04, XOR 05, SLL 06, SRL 07, SRA 08, SLT 09, SLTU 0A, MUL 0B, DIV 0C, REM 0D. Any other value behaves as NOP.
- Single-cycle ops:
  - ADD and SUB wrap mod 2^16.
  - Shift amount is op2[3:0].
  - SLT is a signed compare, SLTU unsigned; result is 16'h0001 or 16'h0000.
  - NOP result = 0.
- MUL: unsigned; result = low 16 bits of the product.
- DIV and REM: unsigned restoring division.
  - op2 == 0 is decided in the same cycle with no FSM entry and no stall: DIV returns 16'hFFFF, REM returns op1.
- FSM states: IDLE, RUN, DONE.
  - IDLE with a MUL/DIV/REM opcode (nonzero divisor):
    - Assert eeo_stall combinationally that cycle.
    - On the clock edge, latch op1, op2 and the opcode; clear the accumulator; set counter = 0; go to RUN.
  - RUN:
    - eeo_stall = 1.
    - One shift-add or shift-subtract step per cycle; counter += 1.
    - At counter == STEPS-1, go to DONE.
  - DONE:
    - eeo_stall = 0; eeo_result = the latched result.
    - The forwarded fields come from the inputs, which ID/EXE has held stable.
    - Next edge: go to IDLE. This edge also advances ID/EXE, so the held instruction is not restarted.
- Latency: MUL/DIV/REM stall for STEPS+1 = 17 cycles; the result is visible in cycle 18.
- While eeo_stall = 1: eeo_wreg_addr = `REG_INVALID, eeo_rwe = `RWE_IDLE, eeo_result = 0 (bubble).
- While iei_en = 0: the same bubble outputs, eeo_stall = 0, and the FSM returns to IDLE on the next edge (aborts any RUN or DONE). Flush has priority over every other condition.
- Reset (async, iei_rst = 0):
  - State IDLE, counter 0, accumulator/quotient/remainder and latched operands 0.
  - Outputs during reset: eeo_stall = 0, eeo_busy = 0, eeo_result = 0, eeo_wreg_addr = `REG_INVALID, eeo_rwe = `RWE_IDLE, eeo_write_to_mem_data = 0.
- Reset released mid-operation: the block resumes from IDLE; no partial result is emitted.
- Input changes during RUN are ignored; only the latched operands are used.
- eeo_busy = (state != IDLE).

Test Plan:
- ADD 16'h7FFF + 16'h0001 → eeo_result 16'h8000, same cycle, eeo_stall 0. SUB 16'h0000 - 16'h0001 → 16'hFFFF.
- SLT with op1 16'hFFFF, op2 16'h0001 → 16'h0001. SLTU with the same operands → 16'h0000. SRA 16'h8000 by 4 → 16'hF800.
- MUL 16'h0123 × 16'h0010 → stall high for 17 cycles with bubble outputs; cycle 18 gives eeo_result 16'h1230 with wreg forwarded and stall 0; next instruction issues the following cycle with no repeat.
- DIV 16'd100 / 16'd7 → 16'd14 after 17 stall cycles. REM of the same operands → 16'd2. DIV by 0 → 16'hFFFF with no stall. REM 16'd9 by 0 → 16'd9.
- Start a MUL, drop iei_en at RUN cycle 5 → next edge IDLE, eeo_stall 0, bubble outputs; then a fresh ADD computes correctly.
- Assert iei_rst low at RUN cycle 8 → outputs take their reset values immediately; after release the FSM is IDLE and the next DIV runs its full 17-cycle stall.
